// File: rtl/apb_mst_pkg.sv
// Shared types and constants for the APB master bridge and its timeout timer.
package apb_mst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int          CNT_W         = 16;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hdead_1eaf;

endpackage

// File: rtl/apb_mst_timer.sv
// PREADY timeout counter with a sticky interrupt and a record of the address that timed out.
module apb_mst_timer
  import apb_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int TIMECNT    = 99
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  access,
  input  logic                  pready,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  timeout,
  output logic                  interrupt,
  output logic [ADDR_WIDTH-1:0] timeout_addr
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMECNT - 1);

  logic [CNT_W-1:0] cnt;

  // A PREADY arriving in the final counted cycle completes normally instead of aborting.
  assign timeout = access && !pready && (cnt == LIMIT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt          <= '0;
      interrupt    <= 1'b0;
      timeout_addr <= '0;
    end else begin
      if (access && !pready && !timeout) cnt <= cnt + 1'b1;
      else                               cnt <= '0;

      // A timeout in the same cycle as clear keeps the flag set.
      if (timeout) begin
        interrupt    <= 1'b1;
        timeout_addr <= paddr;
      end else if (clear) begin
        interrupt    <= 1'b0;
        timeout_addr <= '0;
      end
    end
  end

endmodule

// File: rtl/apb_mst_bridge.sv
// Native valid/ready request to single APB3 transfer, with PREADY timeout.
// Define APB_MST_PSTRB_EN to add req_wstrb / PSTRB byte strobes.
module apb_mst_bridge
  import apb_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMECNT    = 99
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef APB_MST_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic                    ack_vld,
  output logic [DATA_WIDTH-1:0]   ack_rdata,
  output logic                    ack_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic                    clear,
  output logic                    interrupt,
  output logic [ADDR_WIDTH-1:0]   timeout_addr,
  output state_t                  dbg_state
);

  localparam logic [DATA_WIDTH-1:0] TO_RDATA = DATA_WIDTH'(TIMEOUT_RDATA);

  // Handshakes: a request transfers on a rising PCLK edge where req_vld && req_rdy;
  // the requester holds req_* stable until then. ack_vld is a one-cycle pulse with no
  // back-pressure; ack_rdata/ack_err are valid with it and hold until the next ack.

  state_t state;
  logic   timeout;

  assign req_rdy   = (state == IDLE);
  assign dbg_state = state;

  apb_mst_timer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMECNT    (TIMECNT)
  ) u_timer (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .access       (state == ACCESS),
    .pready       (PREADY),
    .clear        (clear),
    .paddr        (PADDR),
    .timeout      (timeout),
    .interrupt    (interrupt),
    .timeout_addr (timeout_addr)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
`ifdef APB_MST_PSTRB_EN
      PSTRB     <= '0;
`endif
      ack_vld   <= 1'b0;
      ack_rdata <= '0;
      ack_err   <= 1'b0;
    end else begin
      ack_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= req_addr;
            PWRITE  <= req_wr;
            PWDATA  <= req_wdata;
`ifdef APB_MST_PSTRB_EN
            PSTRB   <= req_wr ? req_wstrb : '0;
`endif
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || timeout) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            ack_vld   <= 1'b1;
            ack_rdata <= PREADY ? PRDATA  : TO_RDATA;
            ack_err   <= PREADY ? PSLVERR : 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
